// File: rtl/fb_pkg.sv
// Shared framebuffer geometry defaults and arbiter grant encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fb_pkg;
    localparam int FB_ADDR_W   = 19;
    localparam int FB_DATA_W   = 12;
    localparam int FB_H_ACTIVE = 640;
    localparam int FB_V_ACTIVE = 480;
    localparam int FB_SIZE_PIX = FB_H_ACTIVE * FB_V_ACTIVE;

    // Which single-port RAM access is granted for the current cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_SCAN  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;
endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of scan-out, writer handshake, RAM port and pixel output signals.
// Latency: none (wiring only).
// Backpressure: writer side is valid/ready (iWrValid/oWrReady).
interface fb_arbiter_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W
);
    logic              iDE;
    logic [ADDR_W-1:0] iPos;
    logic              iWrValid;
    logic [ADDR_W-1:0] iWrAddr;
    logic [DATA_W-1:0] iWrData;
    logic              oWrReady;
    logic              oMemEn;
    logic              oMemWe;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWData;
    logic [DATA_W-1:0] iMemRData;
    logic [DATA_W-1:0] oPixel;
    logic              oPixDE;
    logic              oWrDropped;

    // Arbiter side: consumes scan/write requests and RAM read data.
    modport slave (
        input  iDE, iPos, iWrValid, iWrAddr, iWrData, iMemRData,
        output oWrReady, oMemEn, oMemWe, oMemAddr, oMemWData,
               oPixel, oPixDE, oWrDropped
    );

    // Environment side: timing generator, writer and RAM.
    modport master (
        output iDE, iPos, iWrValid, iWrAddr, iWrData, iMemRData,
        input  oWrReady, oMemEn, oMemWe, oMemAddr, oMemWData,
               oPixel, oPixDE, oWrDropped
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small FIFO holding pending framebuffer writes ({addr, data} entries).
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: caller must not push when oFull or pop when oEmpty.
module fb_wr_fifo #(
    parameter  int WIDTH = 31,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oHead,
    output logic             oFull,
    output logic             oEmpty,
    output logic [CNT_W-1:0] oCount
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two; simultaneous push and pop keep count.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (iPush) wrPtr <= wrPtr + 1'b1;
            if (iPop)  rdPtr <= rdPtr + 1'b1;
            case ({iPush, iPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge iClk) begin
        if (iPush) mem[wrPtr] <= iPushData;
    end

    assign oHead  = mem[rdPtr];
    assign oFull  = (count == CNT_W'(DEPTH));
    assign oEmpty = (count == '0);
    assign oCount = count;
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win during active video, buffered writes use blanking.
// Latency: pixel out 3 cycles after iPos/iDE; accepted write reaches RAM 2 cycles later at the earliest.
// Backpressure: oWrReady drops while the write buffer is full; writers wait until the next blanking cycle.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int FB_SIZE    = FB_SIZE_PIX
) (
    input logic        iClk,
    input logic        iRst_n,
    fb_arbiter_if.slave bus
);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // One extra bit so FB_SIZE == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(FB_SIZE);

    grant_e            state;
    grant_e            stateNext;
    logic              wrAccept;
    logic              wrInRange;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [ENT_W-1:0]  fifoHead;
    logic [CNT_W-1:0]  fifoCount;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              deD1;
    logic              deD2;
    logic              pixDE;
    logic [DATA_W-1:0] pixel;
    logic              wrDropped;

    // Out-of-range writes still complete the handshake but never enter the buffer.
    assign wrAccept  = bus.iWrValid && !fifoFull;
    assign wrInRange = ({1'b0, bus.iWrAddr} < ADDR_LIMIT);
    assign fifoPush  = wrAccept && wrInRange;

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) uWrFifo (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iPush     (fifoPush),
        .iPushData ({bus.iWrAddr, bus.iWrData}),
        .iPop      (fifoPop),
        .oHead     (fifoHead),
        .oFull     (fifoFull),
        .oEmpty    (fifoEmpty),
        .oCount    (fifoCount)
    );

    // Grant register: names the RAM access presented on the bus this cycle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= GNT_IDLE;
        else         state <= stateNext;
    end

    // Next grant: active video always wins; buffered writes drain only in blanking, popping on decision.
    always_comb begin
        stateNext = GNT_IDLE;
        fifoPop   = 1'b0;
        if (bus.iDE) begin
            stateNext = GNT_SCAN;
        end else if (!fifoEmpty) begin
            stateNext = GNT_WRITE;
            fifoPop   = 1'b1;
        end
    end

    // RAM address/data registers load with the grant decision and hold while idle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            memAddr  <= '0;
            memWData <= '0;
        end else begin
            case (stateNext)
                GNT_SCAN:  memAddr <= bus.iPos;
                GNT_WRITE: begin
                    memAddr  <= fifoHead[ENT_W-1 -: ADDR_W];
                    memWData <= fifoHead[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // DE tracks the address register and RAM stages; blanking forces the pixel to black.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            deD1  <= 1'b0;
            deD2  <= 1'b0;
            pixDE <= 1'b0;
            pixel <= '0;
        end else begin
            deD1  <= bus.iDE;
            deD2  <= deD1;
            pixDE <= deD2;
            pixel <= deD2 ? bus.iMemRData : '0;
        end
    end

    // Sticky indication that a write outside the framebuffer was discarded.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                     wrDropped <= 1'b0;
        else if (wrAccept && !wrInRange) wrDropped <= 1'b1;
    end

    // Ready is derived from the registered count, so a push can never land on a full buffer.
    assert property (@(posedge iClk) disable iff (!iRst_n)
        fifoPush |-> (fifoCount != CNT_W'(FIFO_DEPTH)));

    assign bus.oWrReady   = !fifoFull;
    assign bus.oMemEn     = (state != GNT_IDLE);
    assign bus.oMemWe     = (state == GNT_WRITE);
    assign bus.oMemAddr   = memAddr;
    assign bus.oMemWData  = memWData;
    assign bus.oPixel     = pixel;
    assign bus.oPixDE     = pixDE;
    assign bus.oWrDropped = wrDropped;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with queue-based scoreboard for pixels and RAM writes.
// Stimulus drives on the falling edge; the monitor samples on the falling edge as well.
// Each expected item carries the cycle number at which it must appear.
module tb_fb_arbiter;
    import fb_pkg::*;

    localparam int AW = FB_ADDR_W;
    localparam int DW = FB_DATA_W;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wrExp_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } pixExp_t;

    logic    clk = 1'b0;
    logic    rstN;
    int      cyc = 0;
    int      nChecks = 0;
    int      nFail = 0;
    wrExp_t  wrQ[$];
    pixExp_t pixQ[$];

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    fb_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .FB_SIZE    (FB_SIZE_PIX)
    ) dut (
        .iClk   (clk),
        .iRst_n (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data is the low 12 address bits, one cycle after a read.
    always @(posedge clk) begin
        if (bus.oMemEn && !bus.oMemWe) bus.iMemRData <= bus.oMemAddr[DW-1:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drvWr(input logic v, input int addr, input int data);
        bus.iWrValid = v;
        bus.iWrAddr  = AW'(addr);
        bus.iWrData  = DW'(data);
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel or a RAM write.
    always @(negedge clk) begin : monitor
        pixExp_t pe;
        wrExp_t  we;
        if (rstN) begin
            if (bus.oPixDE) begin
                if (pixQ.size() == 0) begin
                    chk("pix_unexpected", bus.oPixDE, 0);
                end else begin
                    pe = pixQ.pop_front();
                    chk("pix_data", bus.oPixel, pe.data);
                    chk("pix_cycle", cyc, pe.due);
                end
            end else begin
                chk("pix_blank", bus.oPixel, 0);
                if (pixQ.size() != 0 && pixQ[0].due <= cyc) begin
                    pe = pixQ.pop_front();
                    chk("pix_missing", bus.oPixDE, 1);
                end
            end
            if (bus.oMemWe) begin
                chk("wr_en", bus.oMemEn, 1);
                if (wrQ.size() == 0) begin
                    chk("wr_unexpected", bus.oMemWe, 0);
                end else begin
                    we = wrQ.pop_front();
                    chk("wr_addr", bus.oMemAddr, we.addr);
                    chk("wr_data", bus.oMemWData, we.data);
                    chk("wr_cycle", cyc, we.due);
                end
            end else if (wrQ.size() != 0 && wrQ[0].due <= cyc) begin
                we = wrQ.pop_front();
                chk("wr_missing", bus.oMemWe, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int d;
        int a;
        rstN = 1'b0;
        bus.iDE = 1'b0;
        bus.iPos = '0;
        drvWr(1'b0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_memEn", bus.oMemEn, 0);
        chk("rst_memWe", bus.oMemWe, 0);
        chk("rst_memAddr", bus.oMemAddr, 0);
        chk("rst_pixDE", bus.oPixDE, 0);
        chk("rst_ready", bus.oWrReady, 1);
        chk("rst_dropped", bus.oWrDropped, 0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Scan one active line: pixel = address, exactly 3 cycles later, no writes
        for (int i = 0; i < 640; i++) begin
            bus.iDE  = 1'b1;
            bus.iPos = AW'(i);
            pixQ.push_back('{data: DW'(i), due: cyc + 3});
            @(negedge clk);
        end
        bus.iDE = 1'b0;
        bus.iPos = '0;
        repeat (4) @(negedge clk);

        // Single write in blanking: reaches RAM 2 cycles after acceptance
        k = cyc;
        drvWr(1'b1, 100, 'hABC);
        chk("blank_ready", bus.oWrReady, 1);
        wrQ.push_back('{addr: AW'(100), data: DW'('hABC), due: k + 2});
        @(negedge clk);
        drvWr(1'b0, 0, 0);
        repeat (4) @(negedge clk);

        // Backpressure under active video: 4 accepted, 5th held until blanking frees a slot
        for (int j = 0; j < 7; j++) begin
            bus.iDE  = 1'b1;
            bus.iPos = AW'(700 + j);
            pixQ.push_back('{data: DW'(700 + j), due: cyc + 3});
            if (j < 5) drvWr(1'b1, 200 + j, 'h100 + j);
            chk("bp_ready", bus.oWrReady, (j < 4) ? 1 : 0);
            @(negedge clk);
        end
        d = cyc;
        bus.iDE = 1'b0;
        bus.iPos = '0;
        chk("bp_ready_full", bus.oWrReady, 0);
        for (int j = 0; j < 4; j++)
            wrQ.push_back('{addr: AW'(200 + j), data: DW'('h100 + j), due: d + 1 + j});
        @(negedge clk);
        chk("bp_ready_drain", bus.oWrReady, 1);
        wrQ.push_back('{addr: AW'(204), data: DW'('h104), due: d + 5});
        @(negedge clk);
        drvWr(1'b0, 0, 0);
        repeat (6) @(negedge clk);

        // Range boundary: last valid address written, first invalid one dropped
        k = cyc;
        chk("drop_init", bus.oWrDropped, 0);
        drvWr(1'b1, FB_SIZE_PIX - 1, 'h777);
        chk("edge_ready", bus.oWrReady, 1);
        wrQ.push_back('{addr: AW'(FB_SIZE_PIX - 1), data: DW'('h777), due: k + 2});
        @(negedge clk);
        drvWr(1'b1, FB_SIZE_PIX, 'h555);
        chk("oor_ready", bus.oWrReady, 1);
        chk("drop_before", bus.oWrDropped, 0);
        @(negedge clk);
        drvWr(1'b0, 0, 0);
        chk("drop_set", bus.oWrDropped, 1);
        repeat (4) @(negedge clk);
        chk("drop_sticky", bus.oWrDropped, 1);

        // Push/pop collision with two entries buffered at the start of blanking
        a = cyc;
        for (int j = 0; j < 4; j++) begin
            bus.iDE = (j < 2);
            bus.iPos = AW'(800 + j);
            if (j < 2) pixQ.push_back('{data: DW'(800 + j), due: cyc + 3});
            drvWr(1'b1, 300 + j, 'h300 + j);
            chk("coll_ready", bus.oWrReady, 1);
            wrQ.push_back('{addr: AW'(300 + j), data: DW'('h300 + j), due: a + 3 + j});
            @(negedge clk);
        end
        drvWr(1'b0, 0, 0);
        bus.iDE = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-frame with a full buffer: everything clears at once
        for (int j = 0; j < 5; j++) begin
            bus.iDE  = 1'b1;
            bus.iPos = AW'(900 + j);
            pixQ.push_back('{data: DW'(900 + j), due: cyc + 3});
            if (j < 4) drvWr(1'b1, 400 + j, 'h200 + j);
            else       drvWr(1'b0, 0, 0);
            @(negedge clk);
        end
        chk("pre_rst_ready", bus.oWrReady, 0);
        chk("pre_rst_dropped", bus.oWrDropped, 1);
        #2;
        rstN = 1'b0;
        bus.iDE = 1'b0;
        pixQ.delete();
        wrQ.delete();
        #1;
        chk("arst_memEn", bus.oMemEn, 0);
        chk("arst_memWe", bus.oMemWe, 0);
        chk("arst_memAddr", bus.oMemAddr, 0);
        chk("arst_memWData", bus.oMemWData, 0);
        chk("arst_pixel", bus.oPixel, 0);
        chk("arst_pixDE", bus.oPixDE, 0);
        chk("arst_dropped", bus.oWrDropped, 0);
        chk("arst_ready", bus.oWrReady, 1);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("post_rst_memEn", bus.oMemEn, 0);
        chk("post_rst_addr", bus.oMemAddr, 0);
        chk("post_rst_ready", bus.oWrReady, 1);
        // Buffered writes from before reset must never reach the RAM
        repeat (5) @(negedge clk);

        k = cyc;
        drvWr(1'b1, 5, 'h123);
        chk("final_ready", bus.oWrReady, 1);
        wrQ.push_back('{addr: AW'(5), data: DW'('h123), due: k + 2});
        @(negedge clk);
        drvWr(1'b0, 0, 0);
        repeat (5) @(negedge clk);

        chk("pix_leftover", pixQ.size(), 0);
        chk("wr_leftover", wrQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule
